// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
//   Shared definitions for the ARM core pipeline:
//     - EXE_CMD_W and the ALU command encodings driven by ID into EXE
//     - NZCV bit positions inside the 4-bit status value
//     - id_exe_ctrl_t: the decoded control bits carried from ID to EXE
// ---------------------------------------------------------------------------
package arm_pkg;

   localparam int EXE_CMD_W = 4;

   // ALU commands. Several opcodes share an ALU operation: CMP is a SUB
   // without writeback, TST an AND without writeback, LDR/STR use ADD for
   // address generation.
   localparam logic [EXE_CMD_W-1:0] EXE_MOV = 4'b0001;
   localparam logic [EXE_CMD_W-1:0] EXE_MVN = 4'b1001;
   localparam logic [EXE_CMD_W-1:0] EXE_ADD = 4'b0010;
   localparam logic [EXE_CMD_W-1:0] EXE_ADC = 4'b0011;
   localparam logic [EXE_CMD_W-1:0] EXE_SUB = 4'b0100;
   localparam logic [EXE_CMD_W-1:0] EXE_SBC = 4'b0101;
   localparam logic [EXE_CMD_W-1:0] EXE_AND = 4'b0110;
   localparam logic [EXE_CMD_W-1:0] EXE_ORR = 4'b0111;
   localparam logic [EXE_CMD_W-1:0] EXE_EOR = 4'b1000;
   localparam logic [EXE_CMD_W-1:0] EXE_CMP = 4'b0100;
   localparam logic [EXE_CMD_W-1:0] EXE_TST = 4'b0110;
   localparam logic [EXE_CMD_W-1:0] EXE_LDR = 4'b0010;
   localparam logic [EXE_CMD_W-1:0] EXE_STR = 4'b0010;

   // NZCV bit indices within sr_in / sr_out.
   localparam int SR_N = 3;
   localparam int SR_Z = 2;
   localparam int SR_C = 1;
   localparam int SR_V = 0;

   // Control bits that must never take effect for a bubble.
   typedef struct packed {
      logic valid;
      logic wb_en;
      logic mem_r_en;
      logic mem_w_en;
      logic b;
      logic s;
   } id_exe_ctrl_t;

endpackage : arm_pkg

// File: rtl/id_exe_stage_reg_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   W-bit up counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   synchronous, active-high clear
//     inc   in   count this cycle
//     count out  current value
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule : sat_counter

// File: rtl/id_exe_stage_reg.sv
// ---------------------------------------------------------------------------
// id_exe_stage_reg
//   Pipeline register between decode (ID) and execute (EXE).
//   Edge priority: rst > flush > freeze > load.
//     rst    : clear everything, counters included
//     flush  : insert an all-zero bubble; bubble_cnt counts killed valid
//              instructions
//     freeze : hold every output; stall_cnt counts frozen cycles
//     load   : capture the ID fields; when valid_in=0 the control bits are
//              forced low so the captured slot has no side effects
//   All outputs are registered (1-cycle latency, no input-to-output path).
//
//   Optional build macro ID_EXE_FWD_EN adds forwarding fields:
//     src1_in/src2_in -> src1_out/src2_out, and two_src_out.
//
//   Ports:
//     clk, rst                      clock, sync active-high reset
//     freeze, flush                 hazard stall, branch flush
//     valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  control
//     exe_cmd_in[4]                 ALU command
//     pc_in, val_rn_in, val_rm_in   PC+4 and operands (DATA_W)
//     imm_in, shift_operand_in[12]  immediate flag, instr[11:0]
//     dest_in[4], sr_in[4]          destination reg, NZCV
//     *_out                         registered copies of the above
//     is_memory_ins_out             registered mem_r_en | mem_w_en
//     bubble_cnt, stall_cnt         saturating perf counters (CNT_W)
// ---------------------------------------------------------------------------
module id_exe_stage_reg
   import arm_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 freeze,
   input  logic                 flush,
   input  logic                 valid_in,
   input  logic                 wb_en_in,
   input  logic                 mem_r_en_in,
   input  logic                 mem_w_en_in,
   input  logic                 b_in,
   input  logic                 s_in,
   input  logic [EXE_CMD_W-1:0] exe_cmd_in,
   input  logic [DATA_W-1:0]    pc_in,
   input  logic [DATA_W-1:0]    val_rn_in,
   input  logic [DATA_W-1:0]    val_rm_in,
   input  logic                 imm_in,
   input  logic [11:0]          shift_operand_in,
   input  logic [3:0]           dest_in,
   input  logic [3:0]           sr_in,
`ifdef ID_EXE_FWD_EN
   input  logic [3:0]           src1_in,
   input  logic [3:0]           src2_in,
   output logic [3:0]           src1_out,
   output logic [3:0]           src2_out,
   output logic                 two_src_out,
`endif
   output logic                 valid_out,
   output logic                 wb_en_out,
   output logic                 mem_r_en_out,
   output logic                 mem_w_en_out,
   output logic                 b_out,
   output logic                 s_out,
   output logic [EXE_CMD_W-1:0] exe_cmd_out,
   output logic [DATA_W-1:0]    pc_out,
   output logic [DATA_W-1:0]    val_rn_out,
   output logic [DATA_W-1:0]    val_rm_out,
   output logic                 imm_out,
   output logic [11:0]          shift_operand_out,
   output logic [3:0]           dest_out,
   output logic [3:0]           sr_out,
   output logic                 is_memory_ins_out,
   output logic [CNT_W-1:0]     bubble_cnt,
   output logic [CNT_W-1:0]     stall_cnt
);

   id_exe_ctrl_t ctrl_in;
   id_exe_ctrl_t ctrl_q;
   logic         is_mem_q;

   // Gate every control bit with valid_in so an empty slot can never write
   // a register, touch memory or branch.
   always_comb begin
      ctrl_in          = '0;
      ctrl_in.valid    = valid_in;
      ctrl_in.wb_en    = wb_en_in    & valid_in;
      ctrl_in.mem_r_en = mem_r_en_in & valid_in;
      ctrl_in.mem_w_en = mem_w_en_in & valid_in;
      ctrl_in.b        = b_in        & valid_in;
      ctrl_in.s        = s_in        & valid_in;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         ctrl_q            <= '0;
         is_mem_q          <= 1'b0;
         exe_cmd_out       <= '0;
         pc_out            <= '0;
         val_rn_out        <= '0;
         val_rm_out        <= '0;
         imm_out           <= 1'b0;
         shift_operand_out <= '0;
         dest_out          <= '0;
         sr_out            <= '0;
      end else if (!freeze) begin
         ctrl_q            <= ctrl_in;
         // Taken from the gated inputs, not from the registered outputs.
         is_mem_q          <= ctrl_in.mem_r_en | ctrl_in.mem_w_en;
         exe_cmd_out       <= exe_cmd_in;
         pc_out            <= pc_in;
         val_rn_out        <= val_rn_in;
         val_rm_out        <= val_rm_in;
         imm_out           <= imm_in;
         shift_operand_out <= shift_operand_in;
         dest_out          <= dest_in;
         sr_out            <= sr_in;
      end
   end

`ifdef ID_EXE_FWD_EN
   // Forwarding fields follow the data path. two_src_out is a hint to the
   // forwarding unit that Rm is read (register operand or store data); it
   // is taken from the raw mem_w_en_in since valid_out already qualifies it.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         src1_out    <= '0;
         src2_out    <= '0;
         two_src_out <= 1'b0;
      end else if (!freeze) begin
         src1_out    <= src1_in;
         src2_out    <= src2_in;
         two_src_out <= ~imm_in | mem_w_en_in;
      end
   end
`endif

   assign valid_out         = ctrl_q.valid;
   assign wb_en_out         = ctrl_q.wb_en;
   assign mem_r_en_out      = ctrl_q.mem_r_en;
   assign mem_w_en_out      = ctrl_q.mem_w_en;
   assign b_out             = ctrl_q.b;
   assign s_out             = ctrl_q.s;
   assign is_memory_ins_out = is_mem_q;

   // A bubble is counted only when flush kills a real instruction.
   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush & valid_in),
      .count (bubble_cnt)
   );

   // Flush wins over freeze, so a flushed cycle is not a stall.
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (freeze & ~flush),
      .count (stall_cnt)
   );

endmodule : id_exe_stage_reg

// File: tb/tb_id_exe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_exe_stage_reg
//   Self-checking bench for id_exe_stage_reg (CNT_W=4 so saturation is
//   reachable). Directed cases with literal expectations, then randomized
//   traffic compared cycle by cycle against a behavioural model.
//   Build with +define+ID_EXE_FWD_EN to also exercise the forwarding fields.
// ---------------------------------------------------------------------------
module tb_id_exe_stage_reg;

   localparam int DW = 32;
   localparam int CW = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, freeze, flush, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in;
   logic b_in, s_in, imm_in;
   logic [3:0]  exe_cmd_in, dest_in, sr_in, src1_in, src2_in;
   logic [DW-1:0] pc_in, val_rn_in, val_rm_in;
   logic [11:0] shift_operand_in;

   logic valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out;
   logic imm_out, is_memory_ins_out;
   logic [3:0]  exe_cmd_out, dest_out, sr_out;
   logic [DW-1:0] pc_out, val_rn_out, val_rm_out;
   logic [11:0] shift_operand_out;
   logic [CW-1:0] bubble_cnt, stall_cnt;
   logic [3:0]  src1_out, src2_out;
   logic        two_src_out;

`ifndef ID_EXE_FWD_EN
   assign src1_out    = '0;
   assign src2_out    = '0;
   assign two_src_out = 1'b0;
`endif

   id_exe_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk               (clk),
      .rst               (rst),
      .freeze            (freeze),
      .flush             (flush),
      .valid_in          (valid_in),
      .wb_en_in          (wb_en_in),
      .mem_r_en_in       (mem_r_en_in),
      .mem_w_en_in       (mem_w_en_in),
      .b_in              (b_in),
      .s_in              (s_in),
      .exe_cmd_in        (exe_cmd_in),
      .pc_in             (pc_in),
      .val_rn_in         (val_rn_in),
      .val_rm_in         (val_rm_in),
      .imm_in            (imm_in),
      .shift_operand_in  (shift_operand_in),
      .dest_in           (dest_in),
      .sr_in             (sr_in),
`ifdef ID_EXE_FWD_EN
      .src1_in           (src1_in),
      .src2_in           (src2_in),
      .src1_out          (src1_out),
      .src2_out          (src2_out),
      .two_src_out       (two_src_out),
`endif
      .valid_out         (valid_out),
      .wb_en_out         (wb_en_out),
      .mem_r_en_out      (mem_r_en_out),
      .mem_w_en_out      (mem_w_en_out),
      .b_out             (b_out),
      .s_out             (s_out),
      .exe_cmd_out       (exe_cmd_out),
      .pc_out            (pc_out),
      .val_rn_out        (val_rn_out),
      .val_rm_out        (val_rm_out),
      .imm_out           (imm_out),
      .shift_operand_out (shift_operand_out),
      .dest_out          (dest_out),
      .sr_out            (sr_out),
      .is_memory_ins_out (is_memory_ins_out),
      .bubble_cnt        (bubble_cnt),
      .stall_cnt         (stall_cnt)
   );

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic valid, wb, mr, mw, b, s, mem, imm, two;
      logic [3:0] cmd, dest, sr, src1, src2;
      logic [DW-1:0] pc, rn, rm;
      logic [11:0] sh;
      logic [CW-1:0] bub, stl;
   } exp_t;

   exp_t mdl;
   exp_t exp_q[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else pass_cnt++;
   endtask

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      int unsigned n;
      n = int'(v) + 1;
      if (n > (1 << CW) - 1) n = (1 << CW) - 1;
      return CW'(n);
   endfunction

   // What the register must hold after the coming edge.
   function automatic exp_t next_state(input exp_t cur);
      exp_t n;
      n = cur;
      if (rst) begin
         n = '0;
      end else if (flush) begin
         n = '0;
         n.stl = cur.stl;
         n.bub = valid_in ? sat_inc(cur.bub) : cur.bub;
      end else if (freeze) begin
         n.stl = sat_inc(cur.stl);
      end else begin
         n.valid = valid_in;
         n.wb    = valid_in && wb_en_in;
         n.mr    = valid_in && mem_r_en_in;
         n.mw    = valid_in && mem_w_en_in;
         n.b     = valid_in && b_in;
         n.s     = valid_in && s_in;
         n.mem   = n.mr || n.mw;
         n.cmd   = exe_cmd_in;
         n.pc    = pc_in;
         n.rn    = val_rn_in;
         n.rm    = val_rm_in;
         n.imm   = imm_in;
         n.sh    = shift_operand_in;
         n.dest  = dest_in;
         n.sr    = sr_in;
         n.src1  = src1_in;
         n.src2  = src2_in;
         n.two   = !imm_in || mem_w_en_in;
      end
      return n;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      {rst, freeze, flush, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in} = '0;
      exe_cmd_in = '0; dest_in = '0; sr_in = '0; src1_in = '0; src2_in = '0;
      pc_in = '0; val_rn_in = '0; val_rm_in = '0; shift_operand_in = '0;
   endtask

   task automatic random_data();
      valid_in = ($urandom_range(0, 9) < 8);
      wb_en_in = $urandom_range(0, 1); mem_r_en_in = $urandom_range(0, 1);
      mem_w_en_in = $urandom_range(0, 1); b_in = $urandom_range(0, 1);
      s_in = $urandom_range(0, 1); imm_in = $urandom_range(0, 1);
      exe_cmd_in = 4'($urandom); dest_in = 4'($urandom); sr_in = 4'($urandom);
      src1_in = 4'($urandom); src2_in = 4'($urandom);
      pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
      shift_operand_in = 12'($urandom);
   endtask

   // Inputs are set at the falling edge; advance one rising edge and come
   // back to the next falling edge where new inputs may be applied.
   task automatic step();
      exp_t n;
      n = next_state(mdl);
      @(posedge clk);
      mdl = n;
      exp_q.push_back(n);
      @(negedge clk);
   endtask

   // ---------------- scoreboard compare ----------------
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("valid_out", 64'(valid_out), 64'(e.valid));
         chk("wb_en_out", 64'(wb_en_out), 64'(e.wb));
         chk("mem_r_en_out", 64'(mem_r_en_out), 64'(e.mr));
         chk("mem_w_en_out", 64'(mem_w_en_out), 64'(e.mw));
         chk("b_out", 64'(b_out), 64'(e.b));
         chk("s_out", 64'(s_out), 64'(e.s));
         chk("is_memory_ins_out", 64'(is_memory_ins_out), 64'(e.mem));
         chk("exe_cmd_out", 64'(exe_cmd_out), 64'(e.cmd));
         chk("pc_out", 64'(pc_out), 64'(e.pc));
         chk("val_rn_out", 64'(val_rn_out), 64'(e.rn));
         chk("val_rm_out", 64'(val_rm_out), 64'(e.rm));
         chk("imm_out", 64'(imm_out), 64'(e.imm));
         chk("shift_operand_out", 64'(shift_operand_out), 64'(e.sh));
         chk("dest_out", 64'(dest_out), 64'(e.dest));
         chk("sr_out", 64'(sr_out), 64'(e.sr));
         chk("bubble_cnt", 64'(bubble_cnt), 64'(e.bub));
         chk("stall_cnt", 64'(stall_cnt), 64'(e.stl));
`ifdef ID_EXE_FWD_EN
         chk("src1_out", 64'(src1_out), 64'(e.src1));
         chk("src2_out", 64'(src2_out), 64'(e.src2));
         chk("two_src_out", 64'(two_src_out), 64'(e.two));
`endif
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      mdl = '0;
      clear_inputs();
      @(negedge clk);

      // Reset with arbitrary inputs.
      random_data();
      freeze = 1'b1;
      rst = 1'b1;
      step();
      step();
      chk("rst valid_out", 64'(valid_out), 64'd0);
      chk("rst pc_out", 64'(pc_out), 64'd0);
      chk("rst bubble_cnt", 64'(bubble_cnt), 64'd0);
      chk("rst stall_cnt", 64'(stall_cnt), 64'd0);

      // Plain load.
      clear_inputs();
      valid_in = 1'b1; wb_en_in = 1'b1; exe_cmd_in = 4'b0010;
      val_rm_in = 32'h0000_00F0; shift_operand_in = 12'h0A0;
      step();
      chk("load valid_out", 64'(valid_out), 64'd1);
      chk("load wb_en_out", 64'(wb_en_out), 64'd1);
      chk("load exe_cmd_out", 64'(exe_cmd_out), 64'h2);
      chk("load val_rm_out", 64'(val_rm_out), 64'hF0);
      chk("load shift_operand_out", 64'(shift_operand_out), 64'h0A0);
      chk("load is_memory_ins_out", 64'(is_memory_ins_out), 64'd0);

      // Freeze holds the captured PC for 3 cycles.
      pc_in = 32'h0000_0010;
      step();
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pc_in = 32'h100 + 32'(i);
         step();
      end
      chk("freeze pc_out", 64'(pc_out), 64'h10);
      chk("freeze stall_cnt", 64'(stall_cnt), 64'd3);

      // Flush beats freeze.
      flush = 1'b1; valid_in = 1'b1; mem_r_en_in = 1'b1;
      step();
      chk("flush valid_out", 64'(valid_out), 64'd0);
      chk("flush is_memory_ins_out", 64'(is_memory_ins_out), 64'd0);
      chk("flush pc_out", 64'(pc_out), 64'd0);
      chk("flush bubble_cnt", 64'(bubble_cnt), 64'd1);
      chk("flush stall_cnt", 64'(stall_cnt), 64'd3);

      // Stall counter saturation.
      flush = 1'b0; freeze = 1'b1;
      for (int i = 0; i < 20; i++) step();
      chk("sat stall_cnt", 64'(stall_cnt), 64'hF);
      step();
      chk("sat stall_cnt hold", 64'(stall_cnt), 64'hF);

`ifdef ID_EXE_FWD_EN
      clear_inputs();
      valid_in = 1'b1; src1_in = 4'd3; src2_in = 4'd7; imm_in = 1'b1; mem_w_en_in = 1'b1;
      step();
      chk("fwd src1_out", 64'(src1_out), 64'd3);
      chk("fwd src2_out", 64'(src2_out), 64'd7);
      chk("fwd two_src_out", 64'(two_src_out), 64'd1);
      flush = 1'b1;
      step();
      chk("fwd flush src1_out", 64'(src1_out), 64'd0);
      chk("fwd flush src2_out", 64'(src2_out), 64'd0);
      chk("fwd flush two_src_out", 64'(two_src_out), 64'd0);
`endif

      // Mid-operation reset discards the held instruction.
      clear_inputs();
      valid_in = 1'b1; wb_en_in = 1'b1; pc_in = 32'hDEAD_0004;
      step();
      rst = 1'b1;
      step();
      chk("midrst valid_out", 64'(valid_out), 64'd0);
      chk("midrst pc_out", 64'(pc_out), 64'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         random_data();
         rst    = ($urandom_range(0, 99) < 2);
         flush  = ($urandom_range(0, 99) < 12);
         freeze = ($urandom_range(0, 99) < 25);
         step();
      end

      clear_inputs();
      @(posedge clk);
      #2;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      total_cnt++;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_id_exe_stage_reg
